pipa_moding_gen: RTL and testbench

//  Synthesizable PIPA loop model for the AGC simulation top. Consumes the AGC's PIPASW/PIPDAT

---
 rtl/pipa_pkg.sv | 22 ++
 rtl/pipa_axis_chan.sv | 60 ++++++
 rtl/pipa_moding_gen.sv | 85 ++++++++
 tb/tb_pipa_moding_gen.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipa_pkg.sv
// Shared constants and helpers for the PIPA moding loop model.
// Frame geometry, the legal acceleration range, and the acceleration clamp.
package pipa_pkg;

    localparam int FRAME_LEN = 6;
    localparam int NEUTRAL   = FRAME_LEN / 2;
    localparam int ACC_MIN   = -3;
    localparam int ACC_MAX   = 3;
    localparam int ACC_W     = 3;
    localparam int SLOT_W    = $clog2(FRAME_LEN);

    typedef logic [SLOT_W-1:0]        slot_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    // The 3-bit input can encode -4, which lies outside the moding range.
    function automatic acc_t clamp_acc(input acc_t a);
        if (int'(a) < ACC_MIN) return acc_t'(ACC_MIN);
        if (int'(a) > ACC_MAX) return acc_t'(ACC_MAX);
        return a;
    endfunction

endpackage

// File: rtl/pipa_axis_chan.sv
// One PIPA axis: latched acceleration, plus/minus slot decision, pulse gating
// and a saturating signed net-pulse monitor counter.
module pipa_axis_chan
    import pipa_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic                    load_i,
    input  acc_t                    accel_i,
    input  slot_t                   slot_i,
    input  logic                    dat_i,
    input  logic                    dat_rise_i,
    output logic                    p_o,
    output logic                    m_o,
    output logic signed [CNT_W-1:0] net_o
);

    localparam logic signed [CNT_W-1:0] NET_MAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W-1:0] NET_MIN = {1'b1, {(CNT_W-1){1'b0}}};

    acc_t                    acc_q;
    logic signed [CNT_W-1:0] net_q, net_d;
    logic                    plus;
    logic                    gate;

    // The first NEUTRAL+acc slots of each frame pulse plus, the rest minus.
    assign plus = int'(slot_i) < (NEUTRAL + int'(acc_q));

    // Held low during reset so the pulse lines are quiet even with PIPDAT high.
    assign gate = en_i & dat_i & ~rst_i;
    assign p_o  = gate & plus;
    assign m_o  = gate & ~plus;

    always_comb begin
        net_d = net_q;
        if (en_i && dat_rise_i) begin
            if (plus) begin
                if (net_q != NET_MAX) net_d = net_q + CNT_W'(1);
            end else begin
                if (net_q != NET_MIN) net_d = net_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
            net_q <= '0;
        end else begin
            if (load_i) acc_q <= clamp_acc(accel_i);
            net_q <= net_d;
        end
    end

    assign net_o = net_q;

endmodule

// File: rtl/pipa_moding_gen.sv
// PIPA loop model for the AGC simulation top: strobe edge detection, shared
// moding slot counter, frame pulse and skew flag feeding three axis channels.
module pipa_moding_gen
    import pipa_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                    SIM_CLK,
    input  logic                    SIM_RST,
    input  logic                    PIPASW,
    input  logic                    PIPDAT,
    input  logic                    EN,
    input  logic signed [2:0]       ACCEL_X,
    input  logic signed [2:0]       ACCEL_Y,
    input  logic signed [2:0]       ACCEL_Z,
    output logic                    PIPAXp,
    output logic                    PIPAXm,
    output logic                    PIPAYp,
    output logic                    PIPAYm,
    output logic                    PIPAZp,
    output logic                    PIPAZm,
    output logic                    FRAME,
    output logic signed [CNT_W-1:0] NETX,
    output logic signed [CNT_W-1:0] NETY,
    output logic signed [CNT_W-1:0] NETZ,
    output logic                    SKEW_ERR
);

    logic  pswd_q, pdd_q;
    logic  sw_rise, dat_rise;
    logic  slot_adv, wrap;
    slot_t slot_q, slot_d;
    logic  frame_q;
    logic  skew_q;

    assign sw_rise  = PIPASW & ~pswd_q;
    assign dat_rise = PIPDAT & ~pdd_q;
    assign slot_adv = EN & sw_rise;
    assign wrap     = slot_adv & (slot_q == slot_t'(FRAME_LEN - 1));

    always_comb begin
        slot_d = slot_q;
        if (slot_adv) slot_d = wrap ? '0 : slot_q + slot_t'(1);
    end

    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            pswd_q  <= 1'b0;
            pdd_q   <= 1'b0;
            slot_q  <= '0;
            frame_q <= 1'b0;
            skew_q  <= 1'b0;
        end else begin
            pswd_q  <= PIPASW;
            pdd_q   <= PIPDAT;
            slot_q  <= slot_d;
            frame_q <= wrap;
            if (sw_rise && dat_rise) skew_q <= 1'b1;
        end
    end

    assign FRAME    = frame_q;
    assign SKEW_ERR = skew_q;

    // Channels see the registered slot, so a coincident PIPASW edge does not
    // affect the decision made for the PIPDAT edge of the same cycle.
    pipa_axis_chan #(.CNT_W(CNT_W)) u_x (
        .clk_i(SIM_CLK), .rst_i(SIM_RST), .en_i(EN), .load_i(wrap),
        .accel_i(ACCEL_X), .slot_i(slot_q), .dat_i(PIPDAT), .dat_rise_i(dat_rise),
        .p_o(PIPAXp), .m_o(PIPAXm), .net_o(NETX)
    );

    pipa_axis_chan #(.CNT_W(CNT_W)) u_y (
        .clk_i(SIM_CLK), .rst_i(SIM_RST), .en_i(EN), .load_i(wrap),
        .accel_i(ACCEL_Y), .slot_i(slot_q), .dat_i(PIPDAT), .dat_rise_i(dat_rise),
        .p_o(PIPAYp), .m_o(PIPAYm), .net_o(NETY)
    );

    pipa_axis_chan #(.CNT_W(CNT_W)) u_z (
        .clk_i(SIM_CLK), .rst_i(SIM_RST), .en_i(EN), .load_i(wrap),
        .accel_i(ACCEL_Z), .slot_i(slot_q), .dat_i(PIPDAT), .dat_rise_i(dat_rise),
        .p_o(PIPAZp), .m_o(PIPAZm), .net_o(NETZ)
    );

endmodule

// File: tb/tb_pipa_moding_gen.sv
// Directed-sequence bench for pipa_moding_gen with a frame-level reference model;
// a second instance with 4-bit counters exercises saturation on the same stimulus.
module tb_pipa_moding_gen;

    localparam int FL  = 6;
    localparam int NEU = 3;

    logic SIM_CLK = 1'b0;
    logic SIM_RST = 1'b0;
    logic PIPASW = 1'b0, PIPDAT = 1'b0, EN = 1'b0;
    logic signed [2:0] ACCEL_X = '0, ACCEL_Y = '0, ACCEL_Z = '0;

    logic PIPAXp, PIPAXm, PIPAYp, PIPAYm, PIPAZp, PIPAZm, FRAME, SKEW_ERR;
    logic signed [15:0] NETX, NETY, NETZ;
    logic PIPAXp_n, PIPAXm_n, PIPAYp_n, PIPAYm_n, PIPAZp_n, PIPAZm_n, FRAME_n, SKEW_ERR_n;
    logic signed [3:0] NETX_n, NETY_n, NETZ_n;

    pipa_moding_gen #(.CNT_W(16)) dut (
        .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .PIPASW(PIPASW), .PIPDAT(PIPDAT), .EN(EN),
        .ACCEL_X(ACCEL_X), .ACCEL_Y(ACCEL_Y), .ACCEL_Z(ACCEL_Z),
        .PIPAXp(PIPAXp), .PIPAXm(PIPAXm), .PIPAYp(PIPAYp), .PIPAYm(PIPAYm),
        .PIPAZp(PIPAZp), .PIPAZm(PIPAZm), .FRAME(FRAME),
        .NETX(NETX), .NETY(NETY), .NETZ(NETZ), .SKEW_ERR(SKEW_ERR)
    );

    pipa_moding_gen #(.CNT_W(4)) dut4 (
        .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .PIPASW(PIPASW), .PIPDAT(PIPDAT), .EN(EN),
        .ACCEL_X(ACCEL_X), .ACCEL_Y(ACCEL_Y), .ACCEL_Z(ACCEL_Z),
        .PIPAXp(PIPAXp_n), .PIPAXm(PIPAXm_n), .PIPAYp(PIPAYp_n), .PIPAYm(PIPAYm_n),
        .PIPAZp(PIPAZp_n), .PIPAZm(PIPAZm_n), .FRAME(FRAME_n),
        .NETX(NETX_n), .NETY(NETY_n), .NETZ(NETZ_n), .SKEW_ERR(SKEW_ERR_n)
    );

    always #5 SIM_CLK = ~SIM_CLK;

    int nchecks = 0;
    int nerr    = 0;

    // Reference model state: position in frame, latched accel, net totals.
    int m_slot;
    int m_acc[3];
    int m_net[3];
    int m_net4[3];
    bit m_frame, m_skew, m_psw, m_pdd;

    int frames_seen;
    int xp_seen, xm_seen;

    function automatic int sat(input int v, input int w);
        int hi = (1 << (w - 1)) - 1;
        int lo = -(1 << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int accel_of(input int a);
        case (a)
            0:       return int'(ACCEL_X);
            1:       return int'(ACCEL_Y);
            default: return int'(ACCEL_Z);
        endcase
    endfunction

    // A frame holds NEU+acc plus slots counted from slot 0.
    function automatic bit m_plus(input int a);
        return m_slot < (NEU + m_acc[a]);
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_slot = 0; m_frame = 0; m_skew = 0; m_psw = 0; m_pdd = 0;
        for (int a = 0; a < 3; a++) begin
            m_acc[a] = 0; m_net[a] = 0; m_net4[a] = 0;
        end
    endtask

    task automatic check_all();
        logic op[3], om[3];
        logic signed [31:0] n16[3], n4[3];
        bit ep;
        op[0] = PIPAXp; op[1] = PIPAYp; op[2] = PIPAZp;
        om[0] = PIPAXm; om[1] = PIPAYm; om[2] = PIPAZm;
        n16[0] = NETX; n16[1] = NETY; n16[2] = NETZ;
        n4[0] = NETX_n; n4[1] = NETY_n; n4[2] = NETZ_n;
        for (int a = 0; a < 3; a++) begin
            ep = EN && PIPDAT && !SIM_RST && m_plus(a);
            chk($sformatf("p%0d", a), op[a], ep);
            chk($sformatf("m%0d", a), om[a], EN && PIPDAT && !SIM_RST && !m_plus(a));
            chk($sformatf("net%0d", a), n16[a], m_net[a]);
            chk($sformatf("net4_%0d", a), n4[a], m_net4[a]);
        end
        chk("frame", FRAME, m_frame);
        chk("frame4", FRAME_n, m_frame);
        chk("skew", SKEW_ERR, m_skew);
        chk("skew4", SKEW_ERR_n, m_skew);
    endtask

    task automatic step();
        bit sw_r, dat_r;
        int d;
        if (SIM_RST) begin
            model_reset();
        end else begin
            sw_r  = PIPASW && !m_psw;
            dat_r = PIPDAT && !m_pdd;
            if (EN && dat_r) begin
                for (int a = 0; a < 3; a++) begin
                    d = m_plus(a) ? 1 : -1;
                    m_net[a]  = sat(m_net[a] + d, 16);
                    m_net4[a] = sat(m_net4[a] + d, 4);
                end
            end
            if (sw_r && dat_r) m_skew = 1;
            m_frame = 0;
            if (EN && sw_r) begin
                m_slot = (m_slot + 1) % FL;
                if (m_slot == 0) begin
                    for (int a = 0; a < 3; a++)
                        m_acc[a] = (accel_of(a) < -3) ? -3 : ((accel_of(a) > 3) ? 3 : accel_of(a));
                    m_frame = 1;
                end
            end
            m_psw = PIPASW;
            m_pdd = PIPDAT;
        end
        @(posedge SIM_CLK);
        #1;
        if (FRAME === 1'b1) frames_seen++;
        check_all();
    endtask

    task automatic sw_pulse();
        PIPASW = 1'b1; step();
        PIPASW = 1'b0; step();
    endtask

    task automatic dat_pulse();
        PIPDAT = 1'b1;
        #1;
        check_all();
        xp_seen += int'(PIPAXp);
        xm_seen += int'(PIPAXm);
        step();
        PIPDAT = 1'b0; step();
    endtask

    task automatic pulse();
        sw_pulse();
        dat_pulse();
    endtask

    task automatic to_wrap();
        for (int i = 0; i < FL; i++) begin
            pulse();
            if (m_slot == 0) break;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int fbase;

        // Reset state
        EN = 1'b1;
        model_reset();
        #1 SIM_RST = 1'b1;
        #3;
        check_all();
        step(); step();
        SIM_RST = 1'b0;
        step();

        // 1: neutral moding, two frames
        frames_seen = 0; xp_seen = 0; xm_seen = 0;
        repeat (FL) pulse();
        chk("t1_netx_f1", NETX, 0);
        chk("t1_xp_per_frame", xp_seen, 3);
        chk("t1_xm_per_frame", xm_seen, 3);
        repeat (FL) pulse();
        chk("t1_netx_f2", NETX, 0);
        chk("t1_nety_f2", NETY, 0);
        chk("t1_frames", frames_seen, 2);

        // 2: mixed accelerations over two full frames
        ACCEL_X = 3'sd2; ACCEL_Y = -3'sd1; ACCEL_Z = 3'sd0;
        to_wrap();
        base = m_net[0];
        repeat (2 * FL) pulse();
        chk("t2_dx", $signed(NETX) - base, 8);
        chk("t2_dy", $signed(NETY) - (m_net[1] + 4) , -4);
        chk("t2_dz", $signed(NETZ) - m_net[2], 0);

        // 3: accel change mid-frame only takes effect after the wrap
        ACCEL_X = 3'sd0;
        to_wrap();
        repeat (2) pulse();
        ACCEL_X = 3'sd3;
        xp_seen = 0; xm_seen = 0;
        to_wrap();
        chk("t3_xm_cur_frame", xm_seen, 3);
        xp_seen = 0; xm_seen = 0;
        repeat (FL) pulse();
        chk("t3_xm_next", xm_seen, 0);
        chk("t3_xp_next", xp_seen, 6);

        // 4: -4 behaves as -3
        ACCEL_Y = 3'b100;
        to_wrap();
        base = m_net[1];
        repeat (FL) pulse();
        chk("t4_dy", $signed(NETY) - base, -6);

        // 5: saturation on the 4-bit instance, then async reset mid-frame
        repeat (20) pulse();
        chk("t5_netx4_sat", NETX_n, 7);
        repeat (2) pulse();
        PIPDAT = 1'b1;
        #1;
        SIM_RST = 1'b1;
        model_reset();
        #1;
        chk("t5_rst_netx", NETX, 0);
        chk("t5_rst_netx4", NETX_n, 0);
        chk("t5_rst_xp", PIPAXp, 0);
        check_all();
        PIPDAT = 1'b0;
        step();
        SIM_RST = 1'b0;
        step();
        fbase = frames_seen;
        pulse();
        chk("t5_slot1_xp_net", NETX, 1);
        to_wrap();
        chk("t5_frames_after_rst", frames_seen - fbase, 1);

        // 6: disabled model and skew detection
        EN = 1'b0;
        base = m_net[0];
        xp_seen = 0; xm_seen = 0;
        repeat (3) pulse();
        chk("t6_en0_netx", $signed(NETX) - base, 0);
        chk("t6_en0_pulses", xp_seen + xm_seen, 0);
        PIPASW = 1'b1; PIPDAT = 1'b1; step();
        chk("t6_skew_en0", SKEW_ERR, 1);
        PIPASW = 1'b0; PIPDAT = 1'b0; step();
        EN = 1'b1;
        PIPASW = 1'b1; PIPDAT = 1'b1; step();
        PIPASW = 1'b0; PIPDAT = 1'b0; step();
        repeat (4) pulse();
        chk("t6_skew_sticky", SKEW_ERR, 1);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
